// File: rtl/mac_mgnt_master.sv
// rtl/mac_mgnt_master.sv - host-side initiator fanning byte-register reads/writes out to per-port MAC management
// Reads of 1-4 consecutive bytes are gathered little-endian into one 32-bit completion.
module mac_mgnt_master #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rstn_sys,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [PORT_W-1:0]      cmd_port,
  input  logic [7:0]             cmd_addr,
  input  logic [1:0]             cmd_len,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic [NUM_PORTS-1:0]   sys_req_valid,
  output logic                   sys_req_wr,
  output logic [7:0]             sys_req_addr,
  input  logic [NUM_PORTS-1:0]   sys_resp_valid,
  input  logic [NUM_PORTS*8-1:0] sys_resp_data
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_wr;
  logic [PORT_W-1:0]   r_port;
  logic [1:0]          r_len;
  logic [1:0]          r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_asm;
  logic [31:0]         r_rsp_hold;
  logic                r_err;
  logic                r_req_wr;
  logic [7:0]          r_req_addr;

  logic                w_accept;
  logic                w_cmd_port_ok;
  logic                w_resp_hit;
  logic [7:0]          w_resp_byte;
  logic [NUM_PORTS-1:0] w_port_hot;
  logic                w_last;
  logic                w_tmo;

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_last   = (r_idx == r_len);
  assign w_tmo    = (r_cnt == CNT_LAST);

  // Port decode: only the latched target port's strobe and byte are ever looked at.
  always_comb begin
    w_cmd_port_ok = 1'b0;
    w_resp_hit    = 1'b0;
    w_resp_byte   = 8'h00;
    w_port_hot    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (32'(cmd_port) == p) begin
        w_cmd_port_ok = 1'b1;
      end
      if (32'(r_port) == p) begin
        w_port_hot[p] = 1'b1;
        w_resp_hit    = sys_resp_valid[p];
        w_resp_byte   = sys_resp_data[p*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_sys) begin
    if (!rstn_sys) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_cmd_port_ok ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        w_next = r_wr ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        // A byte landing on the timeout cycle still counts as a good response.
        if (w_resp_hit) begin
          w_next = w_last ? S_DONE : S_REQ;
        end else if (w_tmo) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_ready     = (r_state == S_IDLE);
    rsp_valid     = (r_state == S_DONE);
    rsp_err       = (r_state == S_DONE) && r_err;
    rsp_data      = (r_state == S_DONE) ? r_asm : r_rsp_hold;
    sys_req_valid = (r_state == S_REQ) ? w_port_hot : '0;
    sys_req_wr    = r_req_wr;
    sys_req_addr  = r_req_addr;
  end

  always_ff @(posedge clk or negedge rstn_sys) begin
    if (!rstn_sys) begin
      r_wr       <= 1'b0;
      r_port     <= '0;
      r_len      <= 2'd0;
      r_idx      <= 2'd0;
      r_cnt      <= '0;
      r_asm      <= 32'h0;
      r_rsp_hold <= 32'h0;
      r_err      <= 1'b0;
      r_req_wr   <= 1'b0;
      r_req_addr <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr  <= cmd_wr;
            r_port <= cmd_port;
            r_len <= cmd_len;
            r_idx <= 2'd0;
            r_asm <= 32'h0;
            r_err <= !w_cmd_port_ok;
            // Bad-port commands never reach the bus, so its address/wr lines keep their old value.
            if (w_cmd_port_ok) begin
              r_req_wr   <= cmd_wr;
              r_req_addr <= cmd_addr;
            end
          end
        end
        S_REQ: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (w_resp_hit) begin
            r_asm[{r_idx, 3'b000} +: 8] <= w_resp_byte;
            if (!w_last) begin
              r_idx      <= r_idx + 2'd1;
              r_req_addr <= r_req_addr + 8'd1;
            end
          end else if (w_tmo) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_rsp_hold <= r_asm;
        end
        default: begin
          r_idx <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_mgnt_master.sv
// tb/tb_mac_mgnt_master.sv - directed bench for mac_mgnt_master
module tb_mac_mgnt_master;
  localparam int NP = 4;
  localparam int PW = 3;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rstn_sys;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_wr;
  logic [PW-1:0]   cmd_port;
  logic [7:0]      cmd_addr;
  logic [1:0]      cmd_len;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic [NP-1:0]   sys_req_valid;
  logic            sys_req_wr;
  logic [7:0]      sys_req_addr;
  logic [NP-1:0]   sys_resp_valid;
  logic [NP*8-1:0] sys_resp_data;

  int checks = 0;
  int errors = 0;

  logic        d_got;
  int          d_k;
  logic [31:0] d_data;
  logic        d_err;
  int          d_req_n;
  logic [7:0]  d_req_addr [8];
  logic        d_req_bad;
  logic        d_req_wr;

  always #5 clk = ~clk;

  mac_mgnt_master #(.NUM_PORTS(NP), .PORT_W(PW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn_sys(rstn_sys),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_port(cmd_port), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sys_req_valid(sys_req_valid), .sys_req_wr(sys_req_wr), .sys_req_addr(sys_req_addr),
    .sys_resp_valid(sys_resp_valid), .sys_resp_data(sys_resp_data)
  );

  // Issues one command and plays the responder; k counts cycles after the accept edge.
  task automatic drive_cmd(input logic wr, input logic [PW-1:0] port, input logic [7:0] addr,
                           input logic [1:0] len, input int lat, input int nresp,
                           input logic [31:0] bytes, input bit noise);
    int resp_at;
    int served;
    int pend_idx;
    int pi;
    int other;
    d_got = 1'b0; d_k = 0; d_data = '0; d_err = 1'b0;
    d_req_n = 0; d_req_bad = 1'b0; d_req_wr = 1'b0;
    for (int i = 0; i < 8; i++) d_req_addr[i] = 8'h00;
    resp_at = -1; served = 0; pend_idx = 0;
    pi = int'(port);
    other = (pi + 1) % NP;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_port = port; cmd_addr = addr; cmd_len = len;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      sys_resp_valid = '0;
      sys_resp_data = '0;
      if (sys_req_valid != '0) begin
        if (sys_req_valid != (NP'(1) << port)) d_req_bad = 1'b1;
        if (d_req_n < 8) d_req_addr[d_req_n] = sys_req_addr;
        d_req_n++;
        d_req_wr = sys_req_wr;
        if (!wr && served < nresp) begin
          resp_at = k + lat; pend_idx = served; served++;
        end
        if (noise && pi < NP) begin
          sys_resp_valid[pi] = 1'b1; sys_resp_data[pi*8 +: 8] = 8'hEE;
        end
      end
      if (rsp_valid) begin
        d_got = 1'b1; d_k = k; d_data = rsp_data; d_err = rsp_err;
        break;
      end
      if (k == resp_at && pi < NP) begin
        sys_resp_valid[pi] = 1'b1;
        sys_resp_data[pi*8 +: 8] = bytes[pend_idx*8 +: 8];
      end
      if (noise) begin
        sys_resp_valid[other] = 1'b1; sys_resp_data[other*8 +: 8] = 8'h99;
      end
    end
    sys_resp_valid = '0;
    if (!d_got) begin
      errors++; $display("FAIL no_rsp_valid got none within 60 cycles exp one");
    end
  endtask

  task automatic test_reset();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
    checks++; if (sys_req_valid !== 4'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", sys_req_valid); end
    checks++; if (sys_req_wr !== 1'b0) begin errors++; $display("FAIL rst_req_wr got %b exp 0", sys_req_wr); end
    checks++; if (sys_req_addr !== 8'h00) begin errors++; $display("FAIL rst_req_addr got %h exp 00", sys_req_addr); end
  endtask

  task automatic test_read_burst();
    logic [7:0] exp_a;
    drive_cmd(1'b0, 3'd2, 8'h10, 2'd3, 1, 4, 32'hD4C3B2A1, 1'b0);
    checks++; if (d_k !== 9) begin errors++; $display("FAIL rd_latency got %0d exp 9", d_k); end
    checks++; if (d_data !== 32'hD4C3B2A1) begin errors++; $display("FAIL rd_data got %h exp d4c3b2a1", d_data); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", d_err); end
    checks++; if (d_req_n !== 4) begin errors++; $display("FAIL rd_req_count got %0d exp 4", d_req_n); end
    checks++; if (d_req_bad !== 1'b0) begin errors++; $display("FAIL rd_req_port got %b exp 0", d_req_bad); end
    for (int i = 0; i < 4; i++) begin
      exp_a = 8'h10 + 8'(i);
      checks++; if (d_req_addr[i] !== exp_a) begin errors++; $display("FAIL rd_addr%0d got %h exp %h", i, d_req_addr[i], exp_a); end
    end
    @(negedge clk);
    checks++; if (rsp_data !== 32'hD4C3B2A1) begin errors++; $display("FAIL rd_hold got %h exp d4c3b2a1", rsp_data); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_ready_after got %b exp 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse_width got %b exp 0", rsp_valid); end
  endtask

  task automatic test_write();
    drive_cmd(1'b1, 3'd1, 8'h05, 2'd2, 1, 4, 32'hFFFFFFFF, 1'b0);
    checks++; if (d_k !== 2) begin errors++; $display("FAIL wr_latency got %0d exp 2", d_k); end
    checks++; if (d_data !== 32'h0) begin errors++; $display("FAIL wr_data got %h exp 0", d_data); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", d_err); end
    checks++; if (d_req_n !== 1) begin errors++; $display("FAIL wr_req_count got %0d exp 1", d_req_n); end
    checks++; if (d_req_bad !== 1'b0) begin errors++; $display("FAIL wr_req_port got %b exp 0", d_req_bad); end
    checks++; if (d_req_addr[0] !== 8'h05) begin errors++; $display("FAIL wr_addr got %h exp 05", d_req_addr[0]); end
    checks++; if (d_req_wr !== 1'b1) begin errors++; $display("FAIL wr_strobe_wr got %b exp 1", d_req_wr); end
    @(negedge clk);
    checks++; if (sys_req_wr !== 1'b1) begin errors++; $display("FAIL wr_hold got %b exp 1", sys_req_wr); end
    checks++; if (sys_req_valid !== 4'b0) begin errors++; $display("FAIL wr_idle_req got %b exp 0", sys_req_valid); end
  endtask

  task automatic test_timeout();
    drive_cmd(1'b0, 3'd0, 8'h20, 2'd1, 1, 1, 32'h00000055, 1'b0);
    checks++; if (d_k !== 12) begin errors++; $display("FAIL to_latency got %0d exp 12", d_k); end
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", d_err); end
    checks++; if (d_data !== 32'h00000055) begin errors++; $display("FAIL to_data got %h exp 00000055", d_data); end
    checks++; if (d_req_n !== 2) begin errors++; $display("FAIL to_req_count got %0d exp 2", d_req_n); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL to_ready_after got %b exp 1", cmd_ready); end
    // Response on the very cycle the timeout would fire.
    drive_cmd(1'b0, 3'd1, 8'h60, 2'd0, TO, 1, 32'h000000C3, 1'b0);
    checks++; if (d_k !== 10) begin errors++; $display("FAIL to_edge_latency got %0d exp 10", d_k); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL to_edge_err got %b exp 0", d_err); end
    checks++; if (d_data !== 32'h000000C3) begin errors++; $display("FAIL to_edge_data got %h exp 000000c3", d_data); end
  endtask

  task automatic test_bad_port();
    drive_cmd(1'b0, 3'd5, 8'h30, 2'd2, 1, 4, 32'hFFFFFFFF, 1'b0);
    checks++; if (d_k !== 1) begin errors++; $display("FAIL bad_latency got %0d exp 1", d_k); end
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL bad_err got %b exp 1", d_err); end
    checks++; if (d_data !== 32'h0) begin errors++; $display("FAIL bad_data got %h exp 0", d_data); end
    checks++; if (d_req_n !== 0) begin errors++; $display("FAIL bad_req_count got %0d exp 0", d_req_n); end
  endtask

  task automatic test_addr_wrap();
    drive_cmd(1'b0, 3'd3, 8'hFE, 2'd3, 2, 4, 32'h44332211, 1'b1);
    checks++; if (d_k !== 13) begin errors++; $display("FAIL wrap_latency got %0d exp 13", d_k); end
    checks++; if (d_data !== 32'h44332211) begin errors++; $display("FAIL wrap_data got %h exp 44332211", d_data); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", d_err); end
    checks++; if (d_req_bad !== 1'b0) begin errors++; $display("FAIL wrap_req_port got %b exp 0", d_req_bad); end
    checks++; if (d_req_addr[0] !== 8'hFE) begin errors++; $display("FAIL wrap_addr0 got %h exp fe", d_req_addr[0]); end
    checks++; if (d_req_addr[1] !== 8'hFF) begin errors++; $display("FAIL wrap_addr1 got %h exp ff", d_req_addr[1]); end
    checks++; if (d_req_addr[2] !== 8'h00) begin errors++; $display("FAIL wrap_addr2 got %h exp 00", d_req_addr[2]); end
    checks++; if (d_req_addr[3] !== 8'h01) begin errors++; $display("FAIL wrap_addr3 got %h exp 01", d_req_addr[3]); end
  endtask

  task automatic test_reset_mid();
    bit viol;
    viol = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_port = 3'd3; cmd_addr = 8'h40; cmd_len = 2'd0;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn_sys = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL mid_rsp_data got %h exp 0", rsp_data); end
    checks++; if (sys_req_addr !== 8'h00) begin errors++; $display("FAIL mid_req_addr got %h exp 00", sys_req_addr); end
    checks++; if (sys_req_wr !== 1'b0) begin errors++; $display("FAIL mid_req_wr got %b exp 0", sys_req_wr); end
    @(negedge clk);
    rstn_sys = 1'b1;
    sys_resp_valid[3] = 1'b1; sys_resp_data[31:24] = 8'hAB;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      sys_resp_valid = '0;
      if (rsp_valid !== 1'b0 || sys_req_valid !== 4'b0) viol = 1'b1;
    end
    checks++; if (viol !== 1'b0) begin errors++; $display("FAIL mid_late_resp got %b exp 0", viol); end
    drive_cmd(1'b0, 3'd3, 8'h40, 2'd0, 1, 1, 32'h0000007E, 1'b0);
    checks++; if (d_k !== 3) begin errors++; $display("FAIL mid_next_latency got %0d exp 3", d_k); end
    checks++; if (d_data !== 32'h0000007E) begin errors++; $display("FAIL mid_next_data got %h exp 0000007e", d_data); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL mid_next_err got %b exp 0", d_err); end
  endtask

  initial begin
    rstn_sys = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_port = '0; cmd_addr = 8'h00; cmd_len = 2'd0;
    sys_resp_valid = '0; sys_resp_data = '0;
    repeat (3) @(negedge clk);
    rstn_sys = 1'b1;
    @(negedge clk);
    test_reset();
    test_read_burst();
    test_write();
    test_timeout();
    test_bad_port();
    test_addr_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
